// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_pkg
// Purpose  : Shared definitions for the sequential binary-to-BCD converter:
//            FSM state encoding, BCD digit width and the add-3 threshold.
// Revision : 1.0 - initial release
// ============================================================================
package bcd_pkg;

  localparam logic       IDLE = 1'b0;
  localparam logic       CONV = 1'b1;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic {
    S_IDLE = IDLE,
    S_CONV = CONV
  } state_t;

endpackage : bcd_pkg
`default_nettype wire

// File: rtl/bcd_add3.sv
`default_nettype none
// ============================================================================
// Module   : bcd_add3
// Purpose  : Combinational double-dabble digit corrector.
//            o_digit = (i_digit >= 5) ? i_digit + 3 : i_digit
// Ports    : i_digit [3:0] - BCD digit before correction (value <= 9)
//            o_digit [3:0] - corrected digit
// Revision : 1.0 - initial release
// ============================================================================
module bcd_add3
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  // Input never exceeds 9, so +3 tops out at 12 and stays inside the nibble.
  assign o_digit = (i_digit >= ADD3_THRESH) ? (i_digit + 4'd3) : i_digit;

endmodule : bcd_add3
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Purpose  : Sequential binary-to-BCD converter (shift-add-3, one bit per
//            clock). A start accepted in IDLE captures i_bin_in; WIDTH edges
//            later o_bcd_out is updated and o_done pulses for one cycle.
// Ports    : clk        - clock
//            resetn     - synchronous, active-low reset
//            i_start    - conversion request, sampled only in IDLE
//            i_bin_in   - binary operand, captured on the accepting edge
//            o_busy     - high while converting (decoded from state)
//            o_done     - one-cycle pulse, o_bcd_out just updated
//            o_bcd_out  - packed BCD, digit i at [4i+3:4i], digit 0 = ones
//            o_blank    - (BCD_BLANK_LEADING_EN only) leading-zero blanking,
//                         bit i set when digit i and all higher digits are 0;
//                         bit 0 is always clear
// Options  : `define BCD_BLANK_LEADING_EN to add the o_blank port.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         i_start,
  input  logic [WIDTH-1:0]             i_bin_in,
  output logic                         o_busy,
  output logic                         o_done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] o_bcd_out
`ifdef BCD_BLANK_LEADING_EN
  ,
  output logic [DIGITS-1:0]            o_blank
`endif
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_shift_bin;
  logic [BCD_W-1:0]   r_bcd_acc;
  logic [CNT_W-1:0]   r_count;
  logic [BCD_W-1:0]   r_bcd_out;
  logic               r_done;

  logic               w_last;
  logic               w_load;
  logic               w_finish;
  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W-1:0]   w_acc_next;
  logic               w_unused;

  // --------------------------------------------------------------------------
  // Per-digit add-3 correction, all digits in parallel
  // --------------------------------------------------------------------------
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
    bcd_add3 u_add3 (
      .i_digit (r_bcd_acc[BCD_DIGIT_W*gi +: BCD_DIGIT_W]),
      .o_digit (w_corr   [BCD_DIGIT_W*gi +: BCD_DIGIT_W])
    );
  end

  // Corrected accumulator shifted left, operand MSB entering bit 0. The top
  // bit of the corrected value is always zero because the result fits DIGITS.
  assign w_acc_next = {w_corr[BCD_W-2:0], r_shift_bin[WIDTH-1]};
  assign w_unused   = w_corr[BCD_W-1];

  assign w_last = (r_count == CNT_W'(WIDTH - 1));

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_finish     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load       = 1'b1;
          w_state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (w_last) begin
          w_finish     = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand shifter, BCD accumulator, bit counter, result register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_shift_bin <= '0;
      r_bcd_acc   <= '0;
      r_count     <= '0;
      r_bcd_out   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_load) begin
        r_shift_bin <= i_bin_in;
        r_bcd_acc   <= '0;
        r_count     <= '0;
      end else if (r_state == S_CONV) begin
        r_bcd_acc   <= w_acc_next;
        r_shift_bin <= {r_shift_bin[WIDTH-2:0], 1'b0};
        r_count     <= r_count + CNT_W'(1);
      end
      if (w_finish) begin
        r_bcd_out <= w_acc_next;
        r_done    <= 1'b1;
      end
    end
  end

`ifdef BCD_BLANK_LEADING_EN
  // --------------------------------------------------------------------------
  // Leading-zero blanking, registered alongside the result
  // --------------------------------------------------------------------------
  logic [DIGITS-1:0] r_blank;
  logic [DIGITS-1:0] w_blank_next;

  // The ones digit is never blanked so a zero result still shows "0".
  assign w_blank_next[0] = 1'b0;
  for (genvar gb = 1; gb < DIGITS; gb++) begin : g_blank
    assign w_blank_next[gb] = ~|w_acc_next[BCD_W-1:BCD_DIGIT_W*gb];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_blank <= {{(DIGITS-1){1'b1}}, 1'b0};
    end else if (w_finish) begin
      r_blank <= w_blank_next;
    end
  end

  assign o_blank = r_blank;
`endif

  assign o_busy    = (r_state == S_CONV);
  assign o_done    = r_done;
  assign o_bcd_out = r_bcd_out;

endmodule : bin_to_bcd_seq
`default_nettype wire

// File: tb/tb_bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin_to_bcd_seq
// Purpose  : Self-checking bench for bin_to_bcd_seq. Expected results come
//            from decimal arithmetic on the operand (divide / modulo by 10).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd_seq;

  localparam int WIDTH  = 8;
  localparam int DIGITS = 3;
  localparam int LAT    = WIDTH + 1;

  logic                  clk;
  logic                  resetn;
  logic                  i_start;
  logic [WIDTH-1:0]      i_bin_in;
  logic                  o_busy;
  logic                  o_done;
  logic [4*DIGITS-1:0]   o_bcd_out;
`ifdef BCD_BLANK_LEADING_EN
  logic [DIGITS-1:0]     o_blank;
`endif

  int total = 0;
  int bad   = 0;

  bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .i_start   (i_start),
    .i_bin_in  (i_bin_in),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_bcd_out (o_bcd_out)
`ifdef BCD_BLANK_LEADING_EN
    ,
    .o_blank   (o_blank)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: decimal digits of v packed one per nibble.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  // Reference: digit i (i>=1) blanked when v has no more than i decimal digits.
  function automatic logic [DIGITS-1:0] ref_blank(input int v);
    logic [DIGITS-1:0] b;
    int p;
    b = '0;
    p = 10;
    for (int i = 1; i < DIGITS; i++) begin
      b[i] = (v < p);
      p = p * 10;
    end
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_result(input string tag, input int v);
    check({tag, "_bcd"}, 32'(o_bcd_out), 32'(ref_bcd(v)));
`ifdef BCD_BLANK_LEADING_EN
    check({tag, "_blank"}, 32'(o_blank), 32'(ref_blank(v)));
`endif
  endtask

  // One full conversion: checks latency, busy length, result and pulse width.
  task automatic do_conv(input string tag, input int v);
    int lat;
    int busy_cnt;
    i_start  = 1'b1;
    i_bin_in = WIDTH'(v);
    tick();
    i_start  = 1'b0;
    lat      = 1;
    busy_cnt = 0;
    while (!o_done && lat < 4 * LAT) begin
      if (o_busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_busycycles"}, 32'(busy_cnt), 32'(WIDTH));
    check({tag, "_busy_at_done"}, 32'(o_busy), 32'd0);
    check_result(tag, v);
    tick();
    check({tag, "_done_one_cycle"}, 32'(o_done), 32'd0);
    check_result({tag, "_hold"}, v);
  endtask

  initial begin
    int dones;
    int last_done;
    int last_bcd;

    resetn   = 1'b0;
    i_start  = 1'b0;
    i_bin_in = '0;
    tick();
    tick();
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_bcd", 32'(o_bcd_out), 32'd0);
`ifdef BCD_BLANK_LEADING_EN
    check("rst_blank", 32'(o_blank), 32'(ref_blank(0)));
`endif
    resetn = 1'b1;
    tick();

    // Boundary values and a follow-up conversion
    do_conv("zero", 0);
    do_conv("max", 255);
    do_conv("seven", 7);

    // Start pulses while busy are ignored; operand changes have no effect
    i_start  = 1'b1;
    i_bin_in = 8'd100;
    tick();
    i_start  = 1'b0;
    dones    = 0;
    last_bcd = 0;
    for (int s = 1; s < 30; s++) begin
      i_start = (s == 3 || s == 5);
      if (s == 4) i_bin_in = 8'd42;
      tick();
      if (o_done) begin
        dones++;
        last_bcd = 32'(o_bcd_out);
      end
    end
    i_start = 1'b0;
    check("ignore_start_dones", 32'(dones), 32'd1);
    check("ignore_start_bcd", 32'(last_bcd), 32'(ref_bcd(100)));

    // start held high: back-to-back conversions, one every LAT cycles
    i_start   = 1'b1;
    i_bin_in  = 8'd42;
    dones     = 0;
    last_done = -1;
    for (int s = 0; s < 5 * LAT; s++) begin
      tick();
      if (o_busy === o_done) begin
        check("b2b_busy_vs_done", 32'(o_busy), 32'(!o_done));
      end
      if (o_done) begin
        check("b2b_bcd", 32'(o_bcd_out), 32'(ref_bcd(42)));
        if (last_done >= 0) check("b2b_period", 32'(s - last_done), 32'(LAT));
        last_done = s;
        dones++;
      end
    end
    i_start = 1'b0;
    check("b2b_dones", 32'(dones), 32'd5);
    tick();
    tick();

    // Reset in the middle of a conversion discards it
    do_conv("pre_reset", 57);
    i_start  = 1'b1;
    i_bin_in = 8'd200;
    tick();
    i_start = 1'b0;
    tick();
    tick();
    tick();
    resetn = 1'b0;
    tick();
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_done", 32'(o_done), 32'd0);
    check("midrst_bcd", 32'(o_bcd_out), 32'd0);
`ifdef BCD_BLANK_LEADING_EN
    check("midrst_blank", 32'(o_blank), 32'(ref_blank(0)));
`endif
    resetn = 1'b1;
    dones  = 0;
    for (int s = 0; s < 3 * LAT; s++) begin
      tick();
      if (o_done) dones++;
    end
    check("midrst_no_done", 32'(dones), 32'd0);

    // Exhaustive sweep
    for (int v = 0; v < (1 << WIDTH); v++) begin
      do_conv($sformatf("sweep%0d", v), v);
    end

    // Random operands with bin_in scrambled while busy
    for (int n = 0; n < 20; n++) begin
      int v;
      v = int'($urandom_range(0, (1 << WIDTH) - 1));
      i_start  = 1'b1;
      i_bin_in = WIDTH'(v);
      tick();
      i_start  = 1'b0;
      dones    = 0;
      last_bcd = 0;
      for (int s = 1; s < 2 * LAT; s++) begin
        i_bin_in = WIDTH'($urandom);
        tick();
        if (o_done) begin
          dones++;
          last_bcd = 32'(o_bcd_out);
          check($sformatf("rand%0d_latency", n), 32'(s + 1), 32'(LAT));
        end
      end
      check($sformatf("rand%0d_dones", n), 32'(dones), 32'd1);
      check($sformatf("rand%0d_bcd", n), 32'(last_bcd), 32'(ref_bcd(v)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_bin_to_bcd_seq
`default_nettype wire
